pixel_array_ctrl: RTL and testbench

- Frame sequencer for an N-pixel array of PIXEL_SENSOR instances sharing one DATA_W-bit data bus.
- Generates the erase/expose/convert/read control sequence and drives the ADC code counter onto the shared bus during conversion.
- Reads pixels out one at a time through one-hot read strobes and delivers samples on a valid/ready stream.
- Sits between the pixel array and the downstream image buffer; generalises the fixed four-pixel, fixed-width arrangement.

---
 rtl/pixel_array_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl
//   Frame sequencer for an N-pixel sensor array that shares one data bus.
//   Runs erase -> expose -> convert -> per-pixel read, drives the ADC code
//   counter onto the shared bus while converting, and hands each sampled
//   pixel code downstream on a valid/ready stream.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start, continuous   frame request (IDLE only) / auto-restart after frame_done
//   abort               synchronous return to IDLE, no frame_done
//   expose_cycles       exposure length, latched at each frame start (0 -> 1)
//   pix_reset, erase, expose, ramp_en, read[N]   pixel array controls
//   bus_out, bus_oe, bus_in                       shared bus drive / sample
//   pix_data, pix_index, pix_valid, pix_ready     sample stream
//   busy, frame_done    status
//
// All outputs are registered and change on the edge that enters a state.
module pixel_array_ctrl #(
  parameter int N_PIXELS     = 4,
  parameter int DATA_W       = 8,
  parameter int EXP_W        = 16,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_SETTLE  = 2,
  localparam int IDX_W       = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [EXP_W-1:0]    expose_cycles,
  output logic                pix_reset,
  output logic                erase,
  output logic                expose,
  output logic                ramp_en,
  output logic [N_PIXELS-1:0] read,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   pix_data,
  output logic [IDX_W-1:0]    pix_index,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                busy,
  output logic                frame_done
);

  // Counter must hold 2^DATA_W, ERASE_CYCLES, 2^EXP_W-1 and READ_SETTLE.
  localparam int W_A   = (DATA_W + 1 > EXP_W) ? DATA_W + 1 : EXP_W;
  localparam int W_E   = $clog2(ERASE_CYCLES + 1);
  localparam int W_R   = $clog2(READ_SETTLE + 1);
  localparam int W_B   = (W_E > W_R) ? W_E : W_R;
  localparam int CNT_W = (W_A > W_B) ? W_A : W_B;

  localparam logic [CNT_W-1:0]    ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    READ_LAST  = CNT_W'(READ_SETTLE - 1);
  localparam logic [CNT_W-1:0]    CONV_LAST  = CNT_W'((64'd1 << DATA_W) - 64'd1);
  localparam logic [IDX_W-1:0]    PIX_LAST   = IDX_W'(N_PIXELS - 1);
  localparam logic [N_PIXELS-1:0] ONE_HOT0   = N_PIXELS'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ERASE, ST_EXPOSE, ST_CONVERT, ST_READ_STROBE, ST_READ_WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   pix;
  logic [EXP_W-1:0]   exp_len;
  logic [EXP_W-1:0]   exp_clamped;

  assign exp_clamped = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pix_reset  <= 1'b1;
      erase      <= 1'b0;
      expose     <= 1'b0;
      ramp_en    <= 1'b0;
      read       <= '0;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
      pix_data   <= '0;
      pix_index  <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      pix        <= '0;
      exp_len    <= '0;
    end else if (abort) begin
      // Same as reset except the latched exposure, which is reloaded at start.
      state      <= ST_IDLE;
      pix_reset  <= 1'b1;
      erase      <= 1'b0;
      expose     <= 1'b0;
      ramp_en    <= 1'b0;
      read       <= '0;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
      pix_data   <= '0;
      pix_index  <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      pix        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_len   <= exp_clamped;
            state     <= ST_ERASE;
            pix_reset <= 1'b0;
            erase     <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_ERASE: begin
          if (cnt == ERASE_LAST) begin
            state  <= ST_EXPOSE;
            erase  <= 1'b0;
            expose <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_EXPOSE: begin
          if (cnt == CNT_W'(exp_len - EXP_W'(1))) begin
            state   <= ST_CONVERT;
            expose  <= 1'b0;
            ramp_en <= 1'b1;
            bus_oe  <= 1'b1;
            bus_out <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          // bus_oe falls on the same edge read[0] rises, so the last cycle
          // with the bus driven is the one just before the first strobe.
          if (cnt == CONV_LAST) begin
            state   <= ST_READ_STROBE;
            ramp_en <= 1'b0;
            bus_oe  <= 1'b0;
            bus_out <= '0;
            cnt     <= '0;
            pix     <= '0;
            read    <= ONE_HOT0;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            bus_out <= bus_out + DATA_W'(1);
          end
        end
        ST_READ_STROBE: begin
          // Sample on the last settle cycle; strobe drops on the same edge.
          if (cnt == READ_LAST) begin
            state     <= ST_READ_WAIT;
            read      <= '0;
            pix_data  <= bus_in;
            pix_index <= pix;
            pix_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ_WAIT: begin
          // The frame_done cycle is spent here so busy stays high across
          // back-to-back continuous frames.
          if (frame_done) begin
            if (continuous) begin
              exp_len <= exp_clamped;
              state   <= ST_ERASE;
              erase   <= 1'b1;
              cnt     <= '0;
            end else begin
              state     <= ST_IDLE;
              pix_reset <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
            if (pix == PIX_LAST) begin
              frame_done <= 1'b1;
            end else begin
              pix   <= pix + IDX_W'(1);
              read  <= ONE_HOT0 << (pix + IDX_W'(1));
              state <= ST_READ_STROBE;
              cnt   <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl with default parameters.
module tb_pixel_array_ctrl;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expose_cycles = '0;
  logic        pix_ready = 1'b1;
  logic        pix_reset, erase, expose, ramp_en, bus_oe, pix_valid, busy, frame_done;
  logic [3:0]  read;
  logic [7:0]  bus_out, bus_in, pix_data;
  logic [1:0]  pix_index;

  logic [3:0][7:0] pv_cur = '0;

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .expose_cycles(expose_cycles), .pix_reset(pix_reset),
    .erase(erase), .expose(expose), .ramp_en(ramp_en), .read(read),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .pix_data(pix_data),
    .pix_index(pix_index), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pixel model: the strobed pixel drives its stored code onto the bus.
  always_comb begin
    bus_in = 8'h00;
    for (int i = 0; i < NP; i++) if (read[i]) bus_in = pv_cur[i];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-frame monitor, sampling pre-edge values at each rising edge.
  int frame_id = 0;
  int mon_id = 0;
  int cyc = 0, t0 = 0, erase_seen = 0;
  int erase_n, expose_n, conv_n, ramp_n, bus_bad, inv_bad, done_n, len, s_n;
  int read_n [NP];
  int s_data [8];
  int s_idx  [8];

  always @(posedge clk) begin
    if (mon_id != frame_id) begin
      mon_id = frame_id;
      erase_seen = 0; erase_n = 0; expose_n = 0; conv_n = 0; ramp_n = 0;
      bus_bad = 0; inv_bad = 0; done_n = 0; len = 0; s_n = 0;
      for (int i = 0; i < NP; i++) read_n[i] = 0;
    end
    cyc++;
    if (erase) begin
      if (erase_seen == 0) begin erase_seen = 1; t0 = cyc; end
      erase_n++;
    end
    if (expose) expose_n++;
    if (ramp_en) ramp_n++;
    if (bus_oe) begin
      if (bus_out !== 8'(conv_n)) bus_bad++;
      conv_n++;
    end
    for (int i = 0; i < NP; i++) if (read[i]) read_n[i]++;
    if (read != 4'b0 && ($countones(read) != 1 || bus_oe)) inv_bad++;
    if (int'(erase) + int'(expose) + int'(ramp_en) > 1) inv_bad++;
    if (pix_valid && pix_ready && s_n < 8) begin
      s_data[s_n] = int'(pix_data);
      s_idx[s_n]  = int'(pix_index);
      s_n++;
    end
    if (frame_done) begin done_n++; len = cyc - t0; end
  end

  typedef struct {
    int              expc;
    logic [3:0][7:0] pv;
    int              exp_expose;
    int              exp_len;
  } vec_t;

  vec_t vecs [4];
  vec_t v;
  int   busy_drop = 0;
  bit   got;

  task automatic start_frame(input vec_t fv);
    pv_cur = fv.pv;
    expose_cycles = 16'(fv.expc);
    frame_id++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for frame_done (bounded), optionally pulsing start mid-exposure,
  // then steps one more cycle so the monitor has seen the whole frame.
  task automatic wait_done(input bit extra_start);
    bit ok;
    bit fired;
    ok = 1'b0; fired = 1'b0; busy_drop = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (extra_start && expose && !fired) begin
        start = 1'b1;
        expose_cycles = 16'd50;
        fired = 1'b1;
      end
      if (frame_done) begin ok = 1'b1; break; end
      if (!busy) busy_drop = 1;
    end
    chk("frame_done_seen", 32'(ok), 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_frame(input vec_t fv, input string tag);
    chk({tag, ".erase_cycles"}, erase_n, 5);
    chk({tag, ".expose_cycles"}, expose_n, fv.exp_expose);
    chk({tag, ".convert_cycles"}, conv_n, 256);
    chk({tag, ".ramp_cycles"}, ramp_n, 256);
    chk({tag, ".bus_out_seq_bad"}, bus_bad, 0);
    chk({tag, ".invariant_bad"}, inv_bad, 0);
    chk({tag, ".frame_done_count"}, done_n, 1);
    chk({tag, ".frame_len"}, len, fv.exp_len);
    chk({tag, ".samples"}, s_n, NP);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s.read%0d_cycles", tag, i), read_n[i], 2);
      chk($sformatf("%s.pix_data%0d", tag, i), s_data[i], int'(fv.pv[i]));
      chk($sformatf("%s.pix_index%0d", tag, i), s_idx[i], i);
    end
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    chk({tag, ".idle_pix_reset"}, 32'(pix_reset), 1);
  endtask

  initial begin
    vecs[0] = '{10, {8'h80, 8'h60, 8'h40, 8'h20}, 10, 283};
    vecs[1] = '{0,  {8'h44, 8'h33, 8'h22, 8'h11}, 1,  274};
    vecs[2] = '{1,  {8'h5A, 8'hA5, 8'h00, 8'hFF}, 1,  274};
    vecs[3] = '{37, {8'h04, 8'h03, 8'h02, 8'h01}, 37, 310};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst.pix_reset", 32'(pix_reset), 1);
    chk("rst.outputs", {erase, expose, ramp_en, bus_oe, pix_valid, busy, frame_done, read}, 0);
    chk("rst.bus_out", 32'(bus_out), 0);
    chk("rst.pix_data", 32'(pix_data), 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single frames.
    for (int r = 0; r < 4; r++) begin
      start_frame(vecs[r]);
      wait_done(1'b0);
      check_frame(vecs[r], $sformatf("vec%0d", r));
      $display("vec%0d expose_cycles=%0d len=%0d errors=%0d", r, vecs[r].expc, len, errors);
    end

    // Backpressure on pixel 1 for 7 cycles.
    start_frame(vecs[0]);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (pix_valid && pix_index == 2'd1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp.pixel1_valid_seen", 32'(got), 1);
    pix_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("bp.hold_valid", 32'(pix_valid), 1);
      chk("bp.hold_data", 32'(pix_data), 32'h40);
      chk("bp.hold_index", 32'(pix_index), 1);
      chk("bp.hold_read", 32'(read), 0);
    end
    pix_ready = 1'b1;
    @(negedge clk);
    chk("bp.post_valid", 32'(pix_valid), 0);
    chk("bp.read2_after_hs", 32'(read), 32'b0100);
    wait_done(1'b0);
    v = vecs[0];
    v.exp_len = 290;
    check_frame(v, "bp");
    $display("backpressure len=%0d errors=%0d", len, errors);

    // Continuous mode; exposure input changed during frame 1's erase.
    continuous = 1'b1;
    start_frame(vecs[0]);
    expose_cycles = 16'd3;
    got = 1'b0;
    busy_drop = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frame_done) begin got = 1'b1; break; end
      if (!busy) busy_drop = 1;
    end
    chk("cont.frame1_done_seen", 32'(got), 1);
    chk("cont.frame1_expose", expose_n, 10);
    chk("cont.frame1_busy_drop", busy_drop, 0);
    chk("cont.busy_at_done", 32'(busy), 1);
    @(negedge clk);
    chk("cont.erase_after_done", 32'(erase), 1);
    chk("cont.busy_after_done", 32'(busy), 1);
    continuous = 1'b0;
    frame_id++;
    wait_done(1'b0);
    chk("cont.frame2_busy_drop", busy_drop, 0);
    v = vecs[0];
    v.expc = 3; v.exp_expose = 3; v.exp_len = 276;
    check_frame(v, "cont2");
    $display("continuous frame2 len=%0d errors=%0d", len, errors);

    // Abort during conversion at code 0x55.
    start_frame(vecs[0]);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_oe && bus_out == 8'h55) begin got = 1'b1; break; end
    end
    chk("abort.count55_seen", 32'(got), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.bus_oe", 32'(bus_oe), 0);
    chk("abort.ramp_en", 32'(ramp_en), 0);
    chk("abort.pix_reset", 32'(pix_reset), 1);
    chk("abort.frame_done", 32'(frame_done), 0);
    repeat (300) @(negedge clk);
    chk("abort.no_frame_done", done_n, 0);
    start_frame(vecs[0]);
    wait_done(1'b0);
    check_frame(vecs[0], "post_abort");
    $display("abort then frame len=%0d errors=%0d", len, errors);

    // Asynchronous reset while a sample waits in READ_WAIT.
    pix_ready = 1'b0;
    start_frame(vecs[0]);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pix_valid) begin got = 1'b1; break; end
    end
    chk("rstmid.valid_seen", 32'(got), 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid.pix_valid", 32'(pix_valid), 0);
    chk("rstmid.pix_reset", 32'(pix_reset), 1);
    chk("rstmid.busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start_frame(vecs[2]);
    wait_done(1'b0);
    check_frame(vecs[2], "post_reset");
    $display("reset mid-frame then frame len=%0d errors=%0d", len, errors);

    // expose_cycles=0 with a stray start during exposure.
    start_frame(vecs[1]);
    wait_done(1'b1);
    check_frame(vecs[1], "stray_start");
    repeat (3) @(negedge clk);
    chk("stray_start.still_idle", 32'(busy), 0);
    $display("stray start len=%0d errors=%0d", len, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
